// File: rtl/idu_sb_issue.sv
// idu_sb_issue: one-entry issue register between IDU0 and EXU with a per-register pending scoreboard
// and write-back snooping. Define IDU_SB_PERF_CNT_EN to build the RAW/WAW/unit stall counters.
module idu_sb_issue #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_WB_PORTS = 2,
  parameter int NUM_UNITS    = 4,
  parameter int PAYLOAD_W    = 128,
  parameter int AW           = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_rs1_en,
  input  logic [AW-1:0]                in_rs1_addr,
  input  logic                         in_rs2_en,
  input  logic [AW-1:0]                in_rs2_addr,
  input  logic                         in_rd_en,
  input  logic [AW-1:0]                in_rd_addr,
  input  logic [NUM_UNITS-1:0]         in_unit,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic [XLEN-1:0]              rf_rs1_data,
  input  logic [XLEN-1:0]              rf_rs2_data,
  input  logic [NUM_UNITS-1:0]         unit_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_rs1_data,
  output logic [XLEN-1:0]              out_rs2_data,
  output logic                         out_rd_en,
  output logic [AW-1:0]                out_rd_addr,
  output logic [NUM_UNITS-1:0]         out_unit,
  output logic [PAYLOAD_W-1:0]         out_payload,
  input  logic [NUM_WB_PORTS-1:0]      wb_valid,
  input  logic [NUM_WB_PORTS*AW-1:0]   wb_rd_addr,
  input  logic [NUM_WB_PORTS*XLEN-1:0] wb_data,
  output logic [NUM_REGS-1:0]          sb_pending,
  output logic [31:0]                  perf_raw_cnt,
  output logic [31:0]                  perf_waw_cnt,
  output logic [31:0]                  perf_unit_cnt
);

  logic                 held;
  logic                 rs1_en_q;
  logic                 rs2_en_q;
  logic                 rd_en_q;
  logic [AW-1:0]        rs1_addr_q;
  logic [AW-1:0]        rs2_addr_q;
  logic [AW-1:0]        rd_addr_q;
  logic [NUM_UNITS-1:0] unit_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [XLEN-1:0]      rs1_data_q;
  logic [XLEN-1:0]      rs2_data_q;
  logic [NUM_REGS-1:0]  pending;

  logic [XLEN:0]        in_lu1;
  logic [XLEN:0]        in_lu2;
  logic [XLEN:0]        hold_lu1;
  logic [XLEN:0]        hold_lu2;
  logic [XLEN-1:0]      cap_rs1;
  logic [XLEN-1:0]      cap_rs2;
  logic [NUM_REGS-1:0]  wb_clr;
  logic [NUM_REGS-1:0]  set_vec;
  logic                 src1_ok;
  logic                 src2_ok;
  logic                 src_ok;
  logic                 waw_ok;
  logic                 unit_ok;
  logic                 fire;
  logic                 cap;

  // Returns {hit, data}; scanning high to low lets the lowest-numbered port win.
  function automatic logic [XLEN:0] wb_lookup(
    input logic [AW-1:0]                addr,
    input logic [NUM_WB_PORTS-1:0]      v,
    input logic [NUM_WB_PORTS*AW-1:0]   a,
    input logic [NUM_WB_PORTS*XLEN-1:0] d
  );
    logic [XLEN:0] r;
    r = '0;
    for (int i = NUM_WB_PORTS - 1; i >= 0; i--) begin
      if (v[i] && (a[i*AW +: AW] == addr) && (addr != '0)) begin
        r = {1'b1, d[i*XLEN +: XLEN]};
      end
    end
    return r;
  endfunction

  assign in_lu1   = wb_lookup(in_rs1_addr, wb_valid, wb_rd_addr, wb_data);
  assign in_lu2   = wb_lookup(in_rs2_addr, wb_valid, wb_rd_addr, wb_data);
  assign hold_lu1 = wb_lookup(rs1_addr_q, wb_valid, wb_rd_addr, wb_data);
  assign hold_lu2 = wb_lookup(rs2_addr_q, wb_valid, wb_rd_addr, wb_data);

  assign cap_rs1 = in_lu1[XLEN] ? in_lu1[XLEN-1:0] : ((in_rs1_addr == '0) ? '0 : rf_rs1_data);
  assign cap_rs2 = in_lu2[XLEN] ? in_lu2[XLEN-1:0] : ((in_rs2_addr == '0) ? '0 : rf_rs2_data);

  // A same-cycle write-back satisfies a source but never the WAW check on rd.
  assign src1_ok   = ~rs1_en_q | ~pending[rs1_addr_q] | hold_lu1[XLEN];
  assign src2_ok   = ~rs2_en_q | ~pending[rs2_addr_q] | hold_lu2[XLEN];
  assign src_ok    = src1_ok & src2_ok;
  assign waw_ok    = ~(rd_en_q & pending[rd_addr_q]);
  assign unit_ok   = |(unit_ready & unit_q);
  assign out_valid = held & ~flush & src_ok & waw_ok & unit_ok;
  assign fire      = out_valid & out_ready;
  assign in_ready  = ~flush & (~held | fire);
  assign cap       = in_valid & in_ready;

  always_comb begin
    wb_clr  = '0;
    set_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        if (wb_valid[p] && (wb_rd_addr[p*AW +: AW] == AW'(r))) begin
          wb_clr[r] = 1'b1;
        end
      end
      if (fire && rd_en_q && (rd_addr_q == AW'(r))) begin
        set_vec[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~wb_clr) | set_vec;
    end
  end

  // Flush drops the held op but leaves the scoreboard alone; older ops still write back.
  always_ff @(posedge clk) begin
    if (rst) begin
      held       <= 1'b0;
      rs1_en_q   <= 1'b0;
      rs2_en_q   <= 1'b0;
      rd_en_q    <= 1'b0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      unit_q     <= '0;
      payload_q  <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else if (flush) begin
      held <= 1'b0;
    end else if (cap) begin
      held       <= 1'b1;
      rs1_en_q   <= in_rs1_en;
      rs2_en_q   <= in_rs2_en;
      rd_en_q    <= in_rd_en;
      rs1_addr_q <= in_rs1_addr;
      rs2_addr_q <= in_rs2_addr;
      rd_addr_q  <= in_rd_addr;
      unit_q     <= in_unit;
      payload_q  <= in_payload;
      rs1_data_q <= cap_rs1;
      rs2_data_q <= cap_rs2;
    end else if (fire) begin
      held <= 1'b0;
    end else if (held) begin
      if (hold_lu1[XLEN]) rs1_data_q <= hold_lu1[XLEN-1:0];
      if (hold_lu2[XLEN]) rs2_data_q <= hold_lu2[XLEN-1:0];
    end
  end

  assign out_rs1_data = hold_lu1[XLEN] ? hold_lu1[XLEN-1:0] : rs1_data_q;
  assign out_rs2_data = hold_lu2[XLEN] ? hold_lu2[XLEN-1:0] : rs2_data_q;
  assign out_rd_en    = rd_en_q;
  assign out_rd_addr  = rd_addr_q;
  assign out_unit     = unit_q;
  assign out_payload  = payload_q;
  assign sb_pending   = pending;

`ifdef IDU_SB_PERF_CNT_EN
  logic [31:0] raw_cnt;
  logic [31:0] waw_cnt;
  logic [31:0] unit_cnt;
  logic        stall;

  assign stall = held & ~out_valid & ~flush;

  // Each stalled cycle is charged to one cause only: raw before waw before unit.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_cnt  <= '0;
      waw_cnt  <= '0;
      unit_cnt <= '0;
    end else if (stall) begin
      if (!src_ok) begin
        if (raw_cnt != '1) raw_cnt <= raw_cnt + 32'd1;
      end else if (!waw_ok) begin
        if (waw_cnt != '1) waw_cnt <= waw_cnt + 32'd1;
      end else begin
        if (unit_cnt != '1) unit_cnt <= unit_cnt + 32'd1;
      end
    end
  end

  assign perf_raw_cnt  = raw_cnt;
  assign perf_waw_cnt  = waw_cnt;
  assign perf_unit_cnt = unit_cnt;
`else
  assign perf_raw_cnt  = '0;
  assign perf_waw_cnt  = '0;
  assign perf_unit_cnt = '0;
`endif

endmodule
